// File: rtl/bpc_rd_pkg.sv
// Shared definitions for the BPC/MQ code-stream FIFO read scheduler.
package bpc_rd_pkg;

  localparam int unsigned NUM_LANE_DEF = 10;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned BURST_DEF    = 16;
  localparam int unsigned LW_DEF       = 4;

  typedef logic [LW_DEF-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_READ = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bpc_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping at N-1 -> 0.
module bpc_rr_pick #(
  parameter int unsigned N  = 10,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] cand;
  logic [IW-1:0] cand_idx;

  // Walk lanes ptr, ptr+1, ... and keep the first requester seen.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = SW'(ptr_i) + SW'(off);
      if (cand >= SW'(N)) begin
        cand = cand - SW'(N);
      end
      cand_idx = IW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bpc_fifo_rd_sched.sv
// Work-conserving round-robin read scheduler for the code-stream FIFO bank.
// A granted lane is drained for up to BURST bytes; empty lanes are skipped.
module bpc_fifo_rd_sched
  import bpc_rd_pkg::*;
#(
  parameter int unsigned NUM_LANE = NUM_LANE_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned BURST    = BURST_DEF,
  parameter int unsigned LW       = LW_DEF
) (
  input  logic                   clk_rd,
  input  logic                   rst,
  input  logic [NUM_LANE-1:0]    rdempty,
  input  logic [NUM_LANE*DW-1:0] fifo_dout,
  input  logic                   stop_rd,
  input  logic                   halt_to_fifo,
  output logic [NUM_LANE-1:0]    rd_en,
  output logic [DW-1:0]          dout,
  output logic                   dout_vld,
  output logic [LW-1:0]          dout_lane,
  output logic                   busy,
  output logic                   all_done
);
  localparam int unsigned   CW        = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANE - 1);

  rd_state_e     state_q;
  logic [LW-1:0] ptr_q;
  logic [LW-1:0] grant_q;
  logic [CW-1:0] cnt_q;
  logic          dout_vld_q;
  logic [LW-1:0] dout_lane_q;
  logic          all_done_q;

  logic          pick_found;
  logic [LW-1:0] pick_idx;
  logic          grant_empty;
  logic          rd_fire;
  logic          all_empty;
  logic [LW-1:0] ptr_d;

  assign all_empty   = &rdempty;
  assign grant_empty = rdempty[grant_q];
  assign rd_fire     = (state_q == ST_READ) && !grant_empty && !stop_rd;
  assign ptr_d       = (grant_q == LANE_LAST) ? '0 : grant_q + LW'(1);

  bpc_rr_pick #(
    .N  (NUM_LANE),
    .IW (LW)
  ) u_pick (
    .req_i   (~rdempty),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Read strobe: only the granted lane, only when it has data and downstream is ready.
  always_comb begin
    rd_en = '0;
    if (rd_fire) begin
      rd_en[grant_q] = 1'b1;
    end
  end

  // Output byte: select the lane read last cycle; zero when nothing was read.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      if (dout_vld_q && (dout_lane_q == LW'(i))) begin
        dout = fifo_dout[i*DW +: DW];
      end
    end
  end

  // Scheduler FSM, burst counter and registered outputs.
  always_ff @(posedge clk_rd) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      dout_vld_q  <= 1'b0;
      dout_lane_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      dout_vld_q <= rd_fire;
      if (rd_fire) begin
        dout_lane_q <= grant_q;
      end
      all_done_q <= (state_q == ST_IDLE) && all_empty && halt_to_fifo;

      unique case (state_q)
        ST_IDLE: begin
          if (!halt_to_fifo && !all_empty) begin
            state_q <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (pick_found && !halt_to_fifo) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_READ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          // Burst ends on the BURST-th read, or when the lane runs dry.
          if (rd_fire) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_ARB;
              ptr_q   <= ptr_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (grant_empty) begin
            state_q <= ST_ARB;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout_vld  = dout_vld_q;
  assign dout_lane = dout_lane_q;
  assign all_done  = all_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bpc_fifo_rd_sched.sv
// Bench for bpc_fifo_rd_sched: two instances (BURST=16 and BURST=4) fed by lane FIFO models.
module tb_bpc_fifo_rd_sched;
  localparam int unsigned NL    = 10;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic stop_rd = 1'b0;
  logic halt = 1'b0;

  logic [NL-1:0]   rdempty_w [2];
  logic [NL*8-1:0] fd_w      [2];
  logic [NL-1:0]   rd_en_w   [2];
  logic [7:0]      dout_w    [2];
  logic            vld_w     [2];
  logic [3:0]      lane_w    [2];
  logic            busy_w    [2];
  logic            done_w    [2];

  bpc_fifo_rd_sched #(.NUM_LANE(10), .DW(8), .BURST(16), .LW(4)) u_dut16 (
    .clk_rd(clk), .rst(rst), .rdempty(rdempty_w[0]), .fifo_dout(fd_w[0]),
    .stop_rd(stop_rd), .halt_to_fifo(halt), .rd_en(rd_en_w[0]), .dout(dout_w[0]),
    .dout_vld(vld_w[0]), .dout_lane(lane_w[0]), .busy(busy_w[0]), .all_done(done_w[0])
  );

  bpc_fifo_rd_sched #(.NUM_LANE(10), .DW(8), .BURST(4), .LW(4)) u_dut4 (
    .clk_rd(clk), .rst(rst), .rdempty(rdempty_w[1]), .fifo_dout(fd_w[1]),
    .stop_rd(stop_rd), .halt_to_fifo(halt), .rd_en(rd_en_w[1]), .dout(dout_w[1]),
    .dout_vld(vld_w[1]), .dout_lane(lane_w[1]), .busy(busy_w[1]), .all_done(done_w[1])
  );

  // Lane FIFO models: circular buffers, data appears one cycle after rd_en.
  logic [7:0]  mem [2][NL][DEPTH];
  int unsigned wp  [2][NL];
  int unsigned rp  [2][NL];

  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NL; i++)
        rdempty_w[k][i] = (wp[k][i] == rp[k][i]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NL; i++)
        if (rd_en_w[k][i] && (wp[k][i] != rp[k][i])) begin
          fd_w[k][i*8 +: 8] <= mem[k][i][rp[k][i] % DEPTH];
          rp[k][i]          <= rp[k][i] + 1;
        end
  end

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int cyc   = 0;
  logic [NL-1:0] prev_rd = '0;
  logic          prev_rst = 1'b0;
  logic [7:0] obs_b[$];
  int         obs_l[$];
  logic [7:0] exp_b[$];
  int         exp_l[$];
  int         rd_lane[$];
  int         rd_cyc[$];

  function automatic int onehot_idx(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int k, input int lane, input logic [7:0] b);
    mem[k][lane][wp[k][lane] % DEPTH] = b;
    wp[k][lane] = wp[k][lane] + 1;
  endtask

  task automatic clear_logs();
    obs_b.delete(); obs_l.delete(); rd_lane.delete(); rd_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; stop_rd = 1'b0; halt = 1'b0;
    step(2);
    rst = 1'b1;
    clear_logs();
    step(1);
  endtask

  // Reference order: from ptr, take the next non-empty lane, drain min(burst, left), move past it.
  task automatic build_expected(input int k, input int burst, input int ptr0);
    int rem[NL];
    int pos[NL];
    int left, ptr, lane, n;
    exp_b.delete(); exp_l.delete();
    left = 0;
    for (int i = 0; i < NL; i++) begin
      rem[i] = int'(wp[k][i] - rp[k][i]);
      pos[i] = int'(rp[k][i]);
      left += rem[i];
    end
    ptr = ptr0;
    while (left > 0) begin
      lane = 0;
      for (int off = 0; off < NL; off++) begin
        if (rem[(ptr + off) % NL] > 0) begin lane = (ptr + off) % NL; break; end
      end
      n = (rem[lane] < burst) ? rem[lane] : burst;
      for (int j = 0; j < n; j++) begin
        exp_b.push_back(mem[k][lane][pos[lane] % DEPTH]);
        exp_l.push_back(lane);
        pos[lane]++; rem[lane]--; left--;
      end
      ptr = (lane + 1) % NL;
    end
  endtask

  task automatic wait_rd(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (rd_lane.size() >= n) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic wait_drain(input int budget, input bit rand_stall, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rand_stall) stop_rd = ($urandom_range(0, 9) < 3);
      step(1);
      if ((&rdempty_w[sel]) && !busy_w[sel]) begin ok = 1'b1; break; end
    end
    stop_rd = 1'b0;
    step(2);
  endtask

  // Per-cycle protocol watcher; collects the output stream and read strobes.
  task automatic monitor_loop();
    logic exp_vld;
    forever begin
      @(negedge clk);
      cyc++;
      exp_vld = prev_rst && (prev_rd != '0);
      total++;
      if (vld_w[sel] !== exp_vld) begin
        bad++; $display("FAIL mon_dout_vld cyc=%0d got=%b want=%b", cyc, vld_w[sel], exp_vld);
      end
      if (exp_vld) begin
        total++;
        if (int'(lane_w[sel]) != onehot_idx(prev_rd)) begin
          bad++; $display("FAIL mon_dout_lane cyc=%0d got=%0d want=%0d", cyc, lane_w[sel], onehot_idx(prev_rd));
        end
        obs_b.push_back(dout_w[sel]);
        obs_l.push_back(int'(lane_w[sel]));
      end else if (vld_w[sel] === 1'b0) begin
        total++;
        if (dout_w[sel] !== 8'h00) begin
          bad++; $display("FAIL mon_dout_idle cyc=%0d got=%h want=00", cyc, dout_w[sel]);
        end
      end
      total++;
      if ($countones(rd_en_w[sel]) > 1 || (rd_en_w[sel] & rdempty_w[sel]) != '0 ||
          (stop_rd && rd_en_w[sel] != '0)) begin
        bad++; $display("FAIL mon_rd_en cyc=%0d rd_en=%b rdempty=%b stop=%b", cyc, rd_en_w[sel], rdempty_w[sel], stop_rd);
      end
      if (rd_en_w[sel] != '0) begin
        rd_lane.push_back(onehot_idx(rd_en_w[sel]));
        rd_cyc.push_back(cyc);
      end
      prev_rd  = rd_en_w[sel];
      prev_rst = rst;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1);
    fork monitor_loop(); join_none
    step(2);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_en_w[k] !== '0 || dout_w[k] !== 8'h00 || vld_w[k] !== 1'b0 || lane_w[k] !== 4'd0 ||
            busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
          bad++;
          $display("FAIL reset_idle k=%0d c=%0d got rd=%b d=%h v=%b l=%0d busy=%b done=%b want all 0",
                   k, c, rd_en_w[k], dout_w[k], vld_w[k], lane_w[k], busy_w[k], done_w[k]);
        end
      end
    end
    step(1);
  endtask

  task automatic test_two_lanes();
    logic [7:0] cb[6];
    int         cl[6];
    bit ok;
    cb = '{8'hA0, 8'hA1, 8'hA2, 8'h70, 8'h71, 8'h72};
    cl = '{2, 2, 2, 7, 7, 7};
    sel = 0;
    do_reset();
    for (int j = 0; j < 3; j++) begin push(0, 2, 8'hA0 + 8'(j)); push(0, 7, 8'h70 + 8'(j)); end
    wait_drain(200, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL two_lanes_drain: timeout"); end
    total++;
    if (obs_b.size() != 6) begin bad++; $display("FAIL two_lanes_len got=%0d want=6", obs_b.size()); end
    for (int i = 0; i < 6 && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== cb[i] || obs_l[i] != cl[i]) begin
        bad++; $display("FAIL two_lanes_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], cb[i], cl[i]);
      end
    end
  endtask

  task automatic test_full_rotate();
    bit ok;
    int nb, blen;
    sel = 1;
    do_reset();
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < 8; j++) push(1, i, 8'($urandom));
    build_expected(1, 4, 0);
    wait_drain(400, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rotate_drain: timeout"); end
    total++;
    if (obs_b.size() != exp_b.size()) begin
      bad++; $display("FAIL rotate_len got=%0d want=%0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
        bad++; $display("FAIL rotate_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
      end
    end
    nb = 0; blen = 0;
    for (int i = 0; i < rd_lane.size(); i++) begin
      if (i == 0 || rd_lane[i] != rd_lane[i-1] || rd_cyc[i] != rd_cyc[i-1] + 1) begin
        if (i != 0) begin
          total++;
          if (blen != 4) begin bad++; $display("FAIL rotate_burst_len b=%0d got=%0d want=4", nb - 1, blen); end
          total++;
          if (rd_cyc[i] - rd_cyc[i-1] != 2) begin
            bad++; $display("FAIL rotate_gap b=%0d got=%0d want=2", nb, rd_cyc[i] - rd_cyc[i-1]);
          end
        end
        total++;
        if (rd_lane[i] != nb % NL) begin bad++; $display("FAIL rotate_grant b=%0d got=%0d want=%0d", nb, rd_lane[i], nb % NL); end
        nb++; blen = 1;
      end else begin
        blen++;
      end
    end
    total++;
    if (nb != 20 || blen != 4) begin bad++; $display("FAIL rotate_bursts got=%0d/last=%0d want=20/4", nb, blen); end
  endtask

  task automatic test_stall();
    bit ok;
    sel = 1;
    do_reset();
    for (int j = 0; j < 8; j++) begin push(1, 3, 8'h30 + 8'(j)); push(1, 4, 8'h40 + 8'(j)); end
    build_expected(1, 4, 0);
    wait_rd(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_start: timeout"); end
    stop_rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (rd_en_w[1] !== '0 || busy_w[1] !== 1'b1) begin
        bad++; $display("FAIL stall_hold c=%0d got rd=%b busy=%b want 0/1", c, rd_en_w[1], busy_w[1]);
      end
      step(1);
    end
    stop_rd = 1'b0;
    wait_drain(300, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_drain: timeout"); end
    total++;
    if (rd_cyc.size() < 4 || rd_cyc[2] - rd_cyc[1] != 6 || rd_lane[2] != 3 || rd_lane[3] != 3) begin
      bad++; $display("FAIL stall_resume got n=%0d want resume on lane 3 after 5 stalled cycles", rd_cyc.size());
    end
    total++;
    if (obs_b.size() != exp_b.size()) begin
      bad++; $display("FAIL stall_len got=%0d want=%0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
        bad++; $display("FAIL stall_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_halt();
    bit ok;
    int c;
    sel = 0;
    do_reset();
    for (int j = 0; j < 8; j++) push(0, 5, 8'h50 + 8'(j));
    build_expected(0, 16, 0);
    wait_rd(3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL halt_start: timeout"); end
    halt = 1'b1;
    c = 0;
    while (busy_w[0] && c < 100) begin step(1); c++; end
    total++;
    if (busy_w[0]) begin bad++; $display("FAIL halt_idle: timeout"); end
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b0) begin bad++; $display("FAIL halt_done_entry got=%b want=0", done_w[0]); end
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b1) begin bad++; $display("FAIL halt_done got=%b want=1", done_w[0]); end
    total++;
    if (obs_b.size() != 8) begin bad++; $display("FAIL halt_len got=%0d want=8", obs_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
        bad++; $display("FAIL halt_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
      end
    end
    @(posedge clk); #1;
    clear_logs();
    push(0, 7, 8'h77); push(0, 7, 8'h78);
    build_expected(0, 16, 6);
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b1) begin bad++; $display("FAIL halt_done_hold got=%b want=1", done_w[0]); end
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b0) begin bad++; $display("FAIL halt_done_drop got=%b want=0", done_w[0]); end
    step(8);
    total++;
    if (rd_lane.size() != 0 || busy_w[0] !== 1'b0) begin
      bad++; $display("FAIL halt_no_grant got reads=%0d busy=%b want 0/0", rd_lane.size(), busy_w[0]);
    end
    halt = 1'b0;
    wait_drain(200, 1'b0, ok);
    total++;
    if (!ok || obs_b.size() != 2) begin bad++; $display("FAIL halt_release got=%0d want=2", obs_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
        bad++; $display("FAIL halt_rel_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sel = 0;
    do_reset();
    for (int j = 0; j < 2; j++)  push(0, 0, 8'h00 + 8'(j));
    for (int j = 0; j < 10; j++) push(0, 4, 8'h40 + 8'(j));
    for (int j = 0; j < 3; j++)  push(0, 6, 8'h60 + 8'(j));
    wait_rd(5, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_start: timeout"); end
    total++;
    if (rd_lane.size() < 5 || rd_lane[0] != 0 || rd_lane[2] != 4) begin
      bad++; $display("FAIL rstmid_pre_order want lane0 then lane4");
    end
    push(0, 0, 8'h02); push(0, 0, 8'h03);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    clear_logs();
    build_expected(0, 16, 0);
    @(negedge clk);
    total++;
    if (rd_en_w[0] !== '0 || vld_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear got rd=%b vld=%b busy=%b want 0", rd_en_w[0], vld_w[0], busy_w[0]);
    end
    wait_drain(300, 1'b0, ok);
    total++;
    if (!ok || rd_lane.size() == 0 || rd_lane[0] != 0) begin
      bad++; $display("FAIL rstmid_restart got first=%0d want=0", (rd_lane.size() != 0) ? rd_lane[0] : -1);
    end
    total++;
    if (obs_b.size() != exp_b.size()) begin
      bad++; $display("FAIL rstmid_len got=%0d want=%0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
        bad++; $display("FAIL rstmid_byte%0d got=%h/%0d want=%h/%0d", i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int k, nl;
    for (int it = 0; it < 6; it++) begin
      k = it % 2;
      sel = k;
      do_reset();
      nl = 0;
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          nl = $urandom_range(1, 20);
          for (int j = 0; j < nl; j++) push(k, i, 8'($urandom));
        end
      end
      if (nl == 0) push(k, 9, 8'h99);
      build_expected(k, (k == 0) ? 16 : 4, 0);
      wait_drain(2000, 1'b1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand%0d_drain: timeout", it); end
      total++;
      if (obs_b.size() != exp_b.size()) begin
        bad++; $display("FAIL rand%0d_len got=%0d want=%0d", it, obs_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
        total++;
        if (obs_b[i] !== exp_b[i] || obs_l[i] != exp_l[i]) begin
          bad++; $display("FAIL rand%0d_byte%0d got=%h/%0d want=%h/%0d", it, i, obs_b[i], obs_l[i], exp_b[i], exp_l[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_lanes();
    test_full_rotate();
    test_stall();
    test_halt();
    test_reset_mid();
    test_random();
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
